// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath-to-hazard-controller signal bundle
// master drives stage information; slave (the controller) returns enables, valids, forwards and counters.
interface pipe_hazard_ctrl_if;
  logic        ext_stall;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_is_branch;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic [4:0]  ex_waddr;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [4:0]  mem_waddr;
  logic        wb_regwrite;
  logic [4:0]  wb_waddr;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        valid_id;
  logic        valid_ex;
  logic        valid_mem;
  logic        valid_wb;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output ext_stall, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
    output ex_regwrite, ex_memtoreg, ex_waddr,
    output mem_regwrite, mem_memtoreg, mem_waddr,
    output wb_regwrite, wb_waddr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  valid_id, valid_ex, valid_mem, valid_wb,
    input  fwd_a, fwd_b, cycle_cnt, retire_cnt, stall_cnt
  );

  modport slave (
    input  ext_stall, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
    input  ex_regwrite, ex_memtoreg, ex_waddr,
    input  mem_regwrite, mem_memtoreg, mem_waddr,
    input  wb_regwrite, wb_waddr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output valid_id, valid_ex, valid_mem, valid_wb,
    output fwd_a, fwd_b, cycle_cnt, retire_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard detection, stall and ID-operand forwarding control for a 5-stage pipeline
// Performance counters are built only when PIPE_PERF_CNT_EN is defined; otherwise they read 0.
module pipe_hazard_ctrl (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic       valid_id_q, valid_ex_q, valid_mem_q, valid_wb_q;
  logic       ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic       ex_dep, mem_dep;
  logic       load_use, br_ex, br_mem, hz_stall;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic [1:0] fwd_a, fwd_b;

  // $0 is hardwired, so a zero source never matches anything.
  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input logic wr, input logic [4:0] waddr,
                                     input logic vld);
    return use_src & (src != 5'd0) & (src == waddr) & wr & vld;
  endfunction

  assign ex_rs  = src_match(bus.id_use_rs, bus.id_rs, bus.ex_regwrite,  bus.ex_waddr,  valid_ex_q);
  assign ex_rt  = src_match(bus.id_use_rt, bus.id_rt, bus.ex_regwrite,  bus.ex_waddr,  valid_ex_q);
  assign mem_rs = src_match(bus.id_use_rs, bus.id_rs, bus.mem_regwrite, bus.mem_waddr, valid_mem_q);
  assign mem_rt = src_match(bus.id_use_rt, bus.id_rt, bus.mem_regwrite, bus.mem_waddr, valid_mem_q);
  assign wb_rs  = src_match(bus.id_use_rs, bus.id_rs, bus.wb_regwrite,  bus.wb_waddr,  valid_wb_q);
  assign wb_rt  = src_match(bus.id_use_rt, bus.id_rt, bus.wb_regwrite,  bus.wb_waddr,  valid_wb_q);

  assign ex_dep   = ex_rs | ex_rt;
  assign mem_dep  = mem_rs | mem_rt;
  assign load_use = valid_id_q & bus.ex_memtoreg & ex_dep;
  assign br_ex    = valid_id_q & bus.id_is_branch & bus.ex_regwrite & ex_dep;
  assign br_mem   = valid_id_q & bus.id_is_branch & bus.mem_memtoreg & mem_dep;
  assign hz_stall = load_use | br_ex | br_mem;

  // A load result in MEM is not yet available, so only an ALU result forwards from MEM.
  always_comb begin
    fwd_a = FWD_RF;
    if (mem_rs && !bus.mem_memtoreg) fwd_a = FWD_MEM;
    else if (wb_rs)                  fwd_a = FWD_WB;
    fwd_b = FWD_RF;
    if (mem_rt && !bus.mem_memtoreg) fwd_b = FWD_MEM;
    else if (wb_rt)                  fwd_b = FWD_WB;
  end

  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_ex_en  = 1'b1;
    ex_mem_en = 1'b1;
    mem_wb_en = 1'b1;
    if (!rst) begin
      if (bus.ext_stall) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end else if (hz_stall) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
      end
    end
  end

  // A hazard stall holds ID and sends a bubble into EX; the older stages keep draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_id_q  <= 1'b0;
      valid_ex_q  <= 1'b0;
      valid_mem_q <= 1'b0;
      valid_wb_q  <= 1'b0;
    end else if (!bus.ext_stall) begin
      valid_id_q  <= hz_stall ? valid_id_q : 1'b1;
      valid_ex_q  <= valid_id_q & ~hz_stall;
      valid_mem_q <= valid_ex_q;
      valid_wb_q  <= valid_mem_q;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycle_q, retire_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= 32'd0;
      retire_q <= 32'd0;
      stall_q  <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (valid_wb_q & mem_wb_en)      retire_q <= retire_q + 32'd1;
      if (bus.ext_stall | hz_stall)    stall_q  <= stall_q + 32'd1;
    end
  end

  assign bus.cycle_cnt  = cycle_q;
  assign bus.retire_cnt = retire_q;
  assign bus.stall_cnt  = stall_q;
`else
  assign bus.cycle_cnt  = 32'd0;
  assign bus.retire_cnt = 32'd0;
  assign bus.stall_cnt  = 32'd0;
`endif

  assign bus.pc_en     = pc_en;
  assign bus.if_id_en  = if_id_en;
  assign bus.id_ex_en  = id_ex_en;
  assign bus.ex_mem_en = ex_mem_en;
  assign bus.mem_wb_en = mem_wb_en;
  assign bus.valid_id  = valid_id_q;
  assign bus.valid_ex  = valid_ex_q;
  assign bus.valid_mem = valid_mem_q;
  assign bus.valid_wb  = valid_wb_q;
  assign bus.fwd_a     = fwd_a;
  assign bus.fwd_b     = fwd_b;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl (directed scenarios plus random traffic)
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic       rst, ext;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, br;
    logic       exw, exm;
    logic [4:0] exa;
    logic       memw, memm;
    logic [4:0] mema;
    logic       wbw;
    logic [4:0] wba;
  } stim_t;

  typedef struct packed {
    logic [4:0]  en;
    logic [3:0]  vld;
    logic [1:0]  fa, fb;
    logic [31:0] cyc, ret, stl;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mv [4];
  int unsigned mcyc, mret, mstl;
  stim_t       cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stage s (1=EX, 2=MEM, 3=WB) produces a value the ID source r needs.
  function automatic bit hit(input int s, input logic [4:0] r, input logic u, input stim_t t);
    logic w;
    logic [4:0] a;
    case (s)
      1:       begin w = t.exw;  a = t.exa;  end
      2:       begin w = t.memw; a = t.mema; end
      default: begin w = t.wbw;  a = t.wba;  end
    endcase
    return u && (r != 5'd0) && w && (a == r) && mv[s];
  endfunction

  function automatic bit dep(input int s, input stim_t t);
    return hit(s, t.rs, t.use_rs, t) || hit(s, t.rt, t.use_rt, t);
  endfunction

  function automatic bit hazard(input stim_t t);
    if (!mv[0]) return 1'b0;
    if (t.exm && dep(1, t)) return 1'b1;
    if (t.br && dep(1, t)) return 1'b1;
    if (t.br && t.memm && dep(2, t)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] src_sel(input logic [4:0] r, input logic u, input stim_t t);
    if (hit(2, r, u, t) && !t.memm) return 2'b01;
    if (hit(3, r, u, t)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [4:0] enables(input stim_t t);
    if (t.rst) return 5'b11111;
    if (t.ext) return 5'b00000;
    if (hazard(t)) return 5'b00111;
    return 5'b11111;
  endfunction

  function automatic exp_t expect_of(input stim_t t);
    exp_t e;
    e.en  = enables(t);
    e.vld = {mv[0], mv[1], mv[2], mv[3]};
    e.fa  = src_sel(t.rs, t.use_rs, t);
    e.fb  = src_sel(t.rt, t.use_rt, t);
`ifdef PIPE_PERF_CNT_EN
    e.cyc = mcyc; e.ret = mret; e.stl = mstl;
`else
    e.cyc = 0; e.ret = 0; e.stl = 0;
`endif
    return e;
  endfunction

  task automatic advance(input stim_t t);
    bit hz;
    logic [4:0] en;
    hz = hazard(t);
    en = enables(t);
    if (t.rst) begin
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
      mcyc = 0; mret = 0; mstl = 0;
    end else begin
      mcyc++;
      if (t.ext || hz) mstl++;
      if (mv[3] && en[0]) mret++;
      if (!t.ext) begin
        mv[3] = mv[2];
        mv[2] = mv[1];
        mv[1] = hz ? 1'b0 : mv[0];
        mv[0] = 1'b1;
      end
    end
  endtask

  task automatic apply(input stim_t t);
    rst              = t.rst;
    bus.ext_stall    = t.ext;
    bus.id_rs        = t.rs;
    bus.id_rt        = t.rt;
    bus.id_use_rs    = t.use_rs;
    bus.id_use_rt    = t.use_rt;
    bus.id_is_branch = t.br;
    bus.ex_regwrite  = t.exw;
    bus.ex_memtoreg  = t.exm;
    bus.ex_waddr     = t.exa;
    bus.mem_regwrite = t.memw;
    bus.mem_memtoreg = t.memm;
    bus.mem_waddr    = t.mema;
    bus.wb_regwrite  = t.wbw;
    bus.wb_waddr     = t.wba;
  endtask

  task automatic drive(input stim_t t);
    cur = t;
    apply(t);
    exp_q.push_back(expect_of(t));
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    advance(cur);
    #1;
  endtask

  task automatic step(input stim_t t);
    drive(t);
    tick();
  endtask

  function automatic stim_t rnd();
    stim_t t;
    t.rst    = ($urandom_range(0, 63) == 0);
    t.ext    = ($urandom_range(0, 5) == 0);
    t.rs     = 5'($urandom_range(0, 3));
    t.rt     = 5'($urandom_range(0, 3));
    t.use_rs = 1'($urandom_range(0, 1));
    t.use_rt = 1'($urandom_range(0, 1));
    t.br     = 1'($urandom_range(0, 1));
    t.exw    = 1'($urandom_range(0, 1));
    t.exm    = 1'($urandom_range(0, 1));
    t.exa    = 5'($urandom_range(0, 3));
    t.memw   = 1'($urandom_range(0, 1));
    t.memm   = 1'($urandom_range(0, 1));
    t.mema   = 5'($urandom_range(0, 3));
    t.wbw    = 1'($urandom_range(0, 1));
    t.wba    = 5'($urandom_range(0, 3));
    return t;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("enables", {27'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, {27'd0, e.en});
      chk("valids", {28'd0, bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, {28'd0, e.vld});
      chk("fwd_a", {30'd0, bus.fwd_a}, {30'd0, e.fa});
      chk("fwd_b", {30'd0, bus.fwd_b}, {30'd0, e.fb});
      chk("cycle_cnt", bus.cycle_cnt, e.cyc);
      chk("retire_cnt", bus.retire_cnt, e.ret);
      chk("stall_cnt", bus.stall_cnt, e.stl);
    end
  end

  initial begin
    stim_t nop, t;
    int stalls;
    nop = '0;
    t = nop;
    t.rst = 1'b1;
    apply(t);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    mcyc = 0; mret = 0; mstl = 0;

    // Reset state and counters over 10 clean cycles.
    drive(t);
    chk("reset pc_en", {31'd0, bus.pc_en}, 32'd1);
    chk("reset valid_wb", {31'd0, bus.valid_wb}, 32'd0);
    tick();
    drive(nop);
    chk("post-reset valid_id", {31'd0, bus.valid_id}, 32'd0);
    tick();
    repeat (9) step(nop);
    drive(nop);
`ifdef PIPE_PERF_CNT_EN
    chk("cnt cycle", bus.cycle_cnt, 32'd10);
    chk("cnt retire", bus.retire_cnt, 32'd6);
    chk("cnt stall", bus.stall_cnt, 32'd0);
`else
    chk("cnt cycle off", bus.cycle_cnt, 32'd0);
    chk("cnt retire off", bus.retire_cnt, 32'd0);
    chk("cnt stall off", bus.stall_cnt, 32'd0);
`endif
    tick();

    // Load-use: lw $2 in EX, ID reads rs=2.
    t = nop; t.exw = 1; t.exm = 1; t.exa = 2; t.use_rs = 1; t.rs = 2;
    drive(t);
    chk("lu pc_en", {31'd0, bus.pc_en}, 32'd0);
    chk("lu id_ex_en", {31'd0, bus.id_ex_en}, 32'd1);
    tick();
    t = nop; t.memw = 1; t.memm = 1; t.mema = 2; t.use_rs = 1; t.rs = 2;
    drive(t);
    chk("lu bubble valid_ex", {31'd0, bus.valid_ex}, 32'd0);
    chk("lu resume pc_en", {31'd0, bus.pc_en}, 32'd1);
    tick();
    t = nop; t.wbw = 1; t.wba = 2; t.use_rs = 1; t.rs = 2;
    drive(t);
    chk("lu fwd_a wb", {30'd0, bus.fwd_a}, 32'd2);
    tick();
    repeat (3) step(nop);

    // ALU forward: MEM beats WB.
    t = nop; t.memw = 1; t.mema = 5; t.wbw = 1; t.wba = 5; t.use_rt = 1; t.rt = 5;
    drive(t);
    chk("alu fwd_b", {30'd0, bus.fwd_b}, 32'd1);
    chk("alu no stall", {31'd0, bus.pc_en}, 32'd1);
    tick();
    repeat (3) step(nop);

    // Branch on ALU result in EX: one stall then MEM forward.
    t = nop; t.br = 1; t.use_rs = 1; t.rs = 3; t.exw = 1; t.exa = 3;
    drive(t);
    chk("br alu stall", {31'd0, bus.pc_en}, 32'd0);
    tick();
    t = nop; t.br = 1; t.use_rs = 1; t.rs = 3; t.memw = 1; t.mema = 3;
    drive(t);
    chk("br alu resume", {31'd0, bus.pc_en}, 32'd1);
    chk("br alu fwd_a", {30'd0, bus.fwd_a}, 32'd1);
    tick();
    repeat (3) step(nop);

    // Branch on load in EX: two stall cycles.
    stalls = 0;
    t = nop; t.br = 1; t.use_rs = 1; t.rs = 3; t.exw = 1; t.exm = 1; t.exa = 3;
    drive(t); if (!bus.pc_en) stalls++; tick();
    t = nop; t.br = 1; t.use_rs = 1; t.rs = 3; t.memw = 1; t.memm = 1; t.mema = 3;
    drive(t); if (!bus.pc_en) stalls++; tick();
    t = nop; t.br = 1; t.use_rs = 1; t.rs = 3; t.wbw = 1; t.wba = 3;
    drive(t); if (!bus.pc_en) stalls++;
    chk("br lw fwd_a", {30'd0, bus.fwd_a}, 32'd2);
    tick();
    chk("br lw stall cycles", stalls, 32'd2);
    repeat (3) step(nop);

    // $0 never stalls or forwards.
    t = nop; t.exw = 1; t.exm = 1; t.exa = 0; t.use_rs = 1; t.rs = 0; t.memw = 1; t.mema = 0;
    drive(t);
    chk("r0 no stall", {31'd0, bus.pc_en}, 32'd1);
    chk("r0 fwd_a", {30'd0, bus.fwd_a}, 32'd0);
    tick();
    repeat (4) step(nop);

    // ext_stall over a load-use hazard, then one hazard stall.
    t = nop; t.ext = 1; t.exw = 1; t.exm = 1; t.exa = 2; t.use_rs = 1; t.rs = 2;
    for (int i = 0; i < 3; i++) begin
      drive(t);
      chk("ext enables", {27'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 32'd0);
      chk("ext valids frozen", {28'd0, bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, 32'hf);
      tick();
    end
    t.ext = 0;
    drive(t);
    chk("ext release stall", {31'd0, bus.pc_en}, 32'd0);
    tick();
    t = nop; t.memw = 1; t.memm = 1; t.mema = 2; t.use_rs = 1; t.rs = 2;
    drive(t);
    chk("ext release resume", {31'd0, bus.pc_en}, 32'd1);
    tick();
    repeat (3) step(nop);

    // Reset in the middle of a hazard stall.
    t = nop; t.rst = 1; t.exw = 1; t.exm = 1; t.exa = 2; t.use_rs = 1; t.rs = 2;
    drive(t);
    chk("rst mid-stall pc_en", {31'd0, bus.pc_en}, 32'd1);
    tick();
    drive(nop);
    chk("rst mid-stall valid_id", {31'd0, bus.valid_id}, 32'd0);
    tick();

    for (int i = 0; i < 1500; i++) step(rnd());

    step(nop);
    #10;
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ext_stall, input, 1 bit: memory not ready; freezes the whole pipeline.
REQ-004 SHALL have id_rs / id_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-005 SHALL have id_use_rs / id_use_rt, input, 1 bit each: the ID instruction reads rs / rt.
REQ-006 SHALL have id_is_branch, input, 1 bit: the ID instruction compares operands in ID (beq/bne/jr).
REQ-007 SHALL have ex_regwrite, ex_memtoreg, input, 1 bit each; ex_waddr, input, 5 bits: EX destination information.
REQ-008 SHALL have mem_regwrite, mem_memtoreg, input, 1 bit each; mem_waddr, input, 5 bits: MEM destination information.
REQ-009 SHALL have wb_regwrite, input, 1 bit; wb_waddr, input, 5 bits: WB destination information.
REQ-010 SHALL have pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, outputs, 1 bit each: pipeline register load enables.
REQ-011 SHALL have valid_id, valid_ex, valid_mem, valid_wb, outputs, 1 bit each: the stage holds a real instruction.
REQ-012 SHALL have fwd_a / fwd_b, outputs, 2 bits each: ID operand source. 00 = regfile, 01 = MEM ALU result, 10 = WB write data.
REQ-013 SHALL have cycle_cnt, retire_cnt, stall_cnt, outputs, 32 bits each: performance counters.

Function
REQ-014 A match for rs SHALL be defined as id_use_rs & (id_rs != 0) & (id_rs == stage waddr) & stage regwrite & stage valid. The match for rt SHALL be defined the same way.
REQ-015 load_use SHALL be defined as valid_id & ex_memtoreg & (EX match on rs or rt).
REQ-016 br_ex SHALL be defined as valid_id & id_is_branch & ex_regwrite & (EX match on rs or rt).
REQ-017 br_mem SHALL be defined as valid_id & id_is_branch & mem_memtoreg & (MEM match on rs or rt).
REQ-018 hz_stall SHALL be defined as load_use | br_ex | br_mem.
REQ-019 When ext_stall=1, all five enables SHALL be 0 and every valid bit SHALL hold, regardless of hz_stall.
REQ-020 When ext_stall=0 and hz_stall=1:
- pc_en=0 and if_id_en=0.
- id_ex_en=ex_mem_en=mem_wb_en=1.
- On the next edge, valid_ex SHALL be set to 0 (a bubble is inserted).
REQ-021 When neither stall is active, all enables SHALL be 1.
REQ-022 Valid bits SHALL shift on each advancing edge: valid_id<=1, valid_ex<=valid_id, valid_mem<=valid_ex, valid_wb<=valid_mem.
REQ-023 A branch delay slot SHALL be architectural; the block SHALL never flush IF/ID.
REQ-024 fwd_a SHALL select:
- 01 on an rs match with MEM where mem_memtoreg=0;
- else 10 on an rs match with WB;
- else 00.
MEM SHALL have priority over WB. fwd_b SHALL select identically using rt.
REQ-025 All outputs except the counters and valid bits SHALL be combinational from the current inputs and state, with zero latency.
REQ-026 A source equal to register 0 SHALL never cause a stall or a forward.

Reset
REQ-027 While rst=1:
- all valid bits SHALL clear on the clock edge;
- the enables SHALL be forced to 1 so the PC reset vector loads;
- the counters SHALL clear to 0.
REQ-028 Reset asserted mid-stall SHALL abandon the stall. The first cycle after reset SHALL have valid_id=0.

Configuration
REQ-029 The macro PIPE_PERF_CNT_EN SHALL control the performance counters.
- Defined: cycle_cnt increments every non-reset cycle. retire_cnt increments when valid_wb & mem_wb_en. stall_cnt increments when ext_stall | hz_stall. All counters wrap modulo 2^32.
- Undefined: the three counter outputs SHALL be constant 0 and no counter flops SHALL be present.

Verification
REQ-030 Load-use stall:
- Stimulus: lw $2 in EX (ex_memtoreg=1, ex_waddr=2); ID reads rs=2.
- Required: exactly 1 cycle with pc_en=0 and valid_ex=0 next cycle; the following cycle fwd_a=10.
REQ-031 ALU forward:
- Stimulus: MEM has regwrite to $5 with mem_memtoreg=0; WB has regwrite to $5; ID uses rt=5.
- Required: fwd_b=01 (MEM priority), no stall.
REQ-032 Branch dependency:
- Stimulus: beq in ID depends on an add to $3 in EX.
- Required: 1 stall cycle, then fwd_a=01.
- Stimulus: beq depends on a lw in EX.
- Required: 2 stall cycles total.
REQ-033 $0 filter:
- Stimulus: ex_waddr=0, ex_memtoreg=1, id_rs=0, id_use_rs=1.
- Required: no stall, fwd_a=00.
REQ-034 ext_stall during hz_stall:
- Stimulus: ext_stall=1 for 3 cycles while a load-use hazard is present.
- Required: all enables 0 and valid bits frozen; after release, 1 hazard stall cycle.
REQ-035 Counters, with PIPE_PERF_CNT_EN:
- Stimulus: 10 cycles after reset, no stalls.
- Required: cycle_cnt=10, retire_cnt=6, stall_cnt=0.
- Stimulus: same run with the macro undefined.
- Required: all counters read 0.
